sprite_blob: RTL and testbench

SPRITE_BLOB -- requirements
Module: sprite_blob

---
 rtl/sprite_blob.sv | 162 ++++++++++++++++
 tb/tb_sprite_blob.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_blob.sv
// rtl/sprite_blob.sv - single sprite hit/address generator with double-buffered config
module sprite_blob #(
    parameter int ADD_WIDTH   = 16,
    parameter int COORD_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COORD_WIDTH-1:0] cfg_x,
    input  logic [COORD_WIDTH-1:0] cfg_y,
    input  logic [COORD_WIDTH-1:0] cfg_w,
    input  logic [COORD_WIDTH-1:0] cfg_h,
    input  logic [ADD_WIDTH-1:0]   cfg_base,
    input  logic [1:0]             cfg_layer,
    input  logic                   cfg_enable,
    input  logic                   cfg_update,
    input  logic                   frame_start,
    input  logic                   pixel_strobe,
    input  logic [COORD_WIDTH-1:0] pixel_x,
    input  logic [COORD_WIDTH-1:0] pixel_y,
    output logic                   request,
    output logic [ADD_WIDTH-1:0]   address,
    output logic [1:0]             layer
);

    typedef enum logic [1:0] {S_OFF, S_ABOVE, S_ACTIVE, S_BELOW} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [COORD_WIDTH-1:0] r_pnd_x, r_pnd_y, r_pnd_w, r_pnd_h;
    logic [ADD_WIDTH-1:0]   r_pnd_base;
    logic [1:0]             r_pnd_layer;
    logic                   r_pnd_en;
    logic [COORD_WIDTH-1:0] r_act_x, r_act_y, r_act_w, r_act_h;
    logic [ADD_WIDTH-1:0]   r_act_base;
    logic [1:0]             r_act_layer;
    logic                   r_act_en;
    logic [ADD_WIDTH-1:0]   r_row_addr, w_row_nxt;
    logic [COORD_WIDTH-1:0] r_cur_y, w_cur_y_nxt;
    logic                   r_request;
    logic [ADD_WIDTH-1:0]   r_address;
    logic [1:0]             r_layer;

    // An update coinciding with frame_start goes straight through to the active set
    logic [COORD_WIDTH-1:0] w_new_x, w_new_y, w_new_w, w_new_h;
    logic [ADD_WIDTH-1:0]   w_new_base;
    logic [1:0]             w_new_layer;
    logic                   w_new_en;

    assign w_new_x     = cfg_update ? cfg_x      : r_pnd_x;
    assign w_new_y     = cfg_update ? cfg_y      : r_pnd_y;
    assign w_new_w     = cfg_update ? cfg_w      : r_pnd_w;
    assign w_new_h     = cfg_update ? cfg_h      : r_pnd_h;
    assign w_new_base  = cfg_update ? cfg_base   : r_pnd_base;
    assign w_new_layer = cfg_update ? cfg_layer  : r_pnd_layer;
    assign w_new_en    = cfg_update ? cfg_enable : r_pnd_en;

    // Extended by one bit so sprites touching the screen edge never wrap
    logic [COORD_WIDTH:0]   w_x_end, w_y_end, w_cur_y_inc;
    logic [COORD_WIDTH-1:0] w_dx;
    logic                   w_in_x, w_hit;
    logic [ADD_WIDTH-1:0]   w_addr;

    assign w_x_end     = {1'b0, r_act_x} + {1'b0, r_act_w};
    assign w_y_end     = {1'b0, r_act_y} + {1'b0, r_act_h};
    assign w_cur_y_inc = {1'b0, r_cur_y} + (COORD_WIDTH+1)'(1);
    assign w_in_x      = (pixel_x >= r_act_x) && ({1'b0, pixel_x} < w_x_end);
    assign w_dx        = pixel_x - r_act_x;
    assign w_addr      = w_row_nxt + ADD_WIDTH'(w_dx);

    always_ff @(posedge clk) begin
        if (reset) begin
            {r_pnd_x, r_pnd_y, r_pnd_w, r_pnd_h} <= '0;
            {r_pnd_base, r_pnd_layer, r_pnd_en}  <= '0;
            {r_act_x, r_act_y, r_act_w, r_act_h} <= '0;
            {r_act_base, r_act_layer, r_act_en}  <= '0;
        end else begin
            if (cfg_update) begin
                r_pnd_x     <= cfg_x;
                r_pnd_y     <= cfg_y;
                r_pnd_w     <= cfg_w;
                r_pnd_h     <= cfg_h;
                r_pnd_base  <= cfg_base;
                r_pnd_layer <= cfg_layer;
                r_pnd_en    <= cfg_enable;
            end
            if (frame_start) begin
                r_act_x     <= w_new_x;
                r_act_y     <= w_new_y;
                r_act_w     <= w_new_w;
                r_act_h     <= w_new_h;
                r_act_base  <= w_new_base;
                r_act_layer <= w_new_layer;
                r_act_en    <= w_new_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_OFF;
            r_row_addr <= '0;
            r_cur_y    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_row_addr <= w_row_nxt;
            r_cur_y    <= w_cur_y_nxt;
        end
    end

    // Row advance and the bottom-edge check are resolved before the hit test
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row_addr;
        w_cur_y_nxt = r_cur_y;
        w_hit       = 1'b0;
        if (frame_start) begin
            w_state_nxt = (w_new_en && (w_new_w != '0) && (w_new_h != '0)) ? S_ABOVE : S_OFF;
        end else if (pixel_strobe) begin
            case (r_state)
                S_ABOVE: begin
                    if (pixel_y == r_act_y) begin
                        w_state_nxt = S_ACTIVE;
                        w_row_nxt   = r_act_base;
                        w_cur_y_nxt = r_act_y;
                    end
                end
                S_ACTIVE: begin
                    if ({1'b0, pixel_y} == w_cur_y_inc) begin
                        w_row_nxt   = r_row_addr + ADD_WIDTH'(r_act_w);
                        w_cur_y_nxt = r_cur_y + COORD_WIDTH'(1);
                    end
                    if ({1'b0, pixel_y} == w_y_end) begin
                        w_state_nxt = S_BELOW;
                    end
                end
                default: ;
            endcase
            w_hit = (w_state_nxt == S_ACTIVE) && w_in_x;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_request <= 1'b0;
            r_address <= '0;
            r_layer   <= '0;
        end else if (frame_start) begin
            r_request <= 1'b0;
        end else if (pixel_strobe) begin
            r_request <= w_hit;
            r_layer   <= r_act_layer;
            if (w_hit) begin
                r_address <= w_addr;
            end
        end
    end

    assign request = r_request;
    assign address = r_address;
    assign layer   = r_layer;

endmodule

// File: tb/tb_sprite_blob.sv
// tb/tb_sprite_blob.sv - scoreboard bench for sprite_blob
module tb_sprite_blob;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  cfg_x = '0, cfg_y = '0, cfg_w = '0, cfg_h = '0;
    logic [15:0] cfg_base = '0;
    logic [1:0]  cfg_layer = '0;
    logic        cfg_enable = 1'b0, cfg_update = 1'b0, frame_start = 1'b0;
    logic        pixel_strobe = 1'b0;
    logic [9:0]  pixel_x = '0, pixel_y = '0;
    logic        request;
    logic [15:0] address;
    logic [1:0]  layer;

    typedef struct packed {
        logic        req;
        logic [15:0] addr;
        logic [1:0]  lay;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_pass = 0;
    int    n_total = 0;
    logic  due = 1'b0;
    exp_t  mon_e;
    string mon_n;

    sprite_blob #(.ADD_WIDTH(16), .COORD_WIDTH(10)) dut (
        .clk(clk), .reset(reset),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .cfg_base(cfg_base), .cfg_layer(cfg_layer), .cfg_enable(cfg_enable),
        .cfg_update(cfg_update), .frame_start(frame_start),
        .pixel_strobe(pixel_strobe), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .request(request), .address(address), .layer(layer)
    );

    always #5 clk = ~clk;

    always @(posedge clk) due <= pixel_strobe && !reset && !frame_start;

    always @(negedge clk) begin
        if (due) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output: got req=%0b addr=%h layer=%0d, no expectation queued",
                         request, address, layer);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                if (request === mon_e.req && address === mon_e.addr && layer === mon_e.lay)
                    n_pass++;
                else
                    $display("FAIL %s: got req=%0b addr=%h layer=%0d, exp req=%0b addr=%h layer=%0d",
                             mon_n, request, address, layer, mon_e.req, mon_e.addr, mon_e.lay);
            end
        end
    end

    task automatic chk(input string nm, input logic [18:0] got, input logic [18:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, exp %h", nm, got, exp);
    endtask

    task automatic strobe(input int px, input int py, input logic er,
                          input logic [15:0] ea, input logic [1:0] el, input string nm);
        @(posedge clk); #1;
        pixel_x      = px[9:0];
        pixel_y      = py[9:0];
        pixel_strobe = 1'b1;
        exp_q.push_back('{er, ea, el});
        name_q.push_back(nm);
        @(posedge clk); #1;
        pixel_strobe = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic set_cfg(input int x, input int y, input int w, input int h,
                           input logic [15:0] base, input logic [1:0] lay,
                           input logic en, input logic with_fs);
        @(posedge clk); #1;
        cfg_x = x[9:0]; cfg_y = y[9:0]; cfg_w = w[9:0]; cfg_h = h[9:0];
        cfg_base = base; cfg_layer = lay; cfg_enable = en;
        cfg_update  = 1'b1;
        frame_start = with_fs;
        @(posedge clk); #1;
        cfg_update  = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_fs();
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, exp finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_outputs", {request, address, layer}, 19'h0);

        // No config loaded yet: a frame must stay dark
        pulse_fs();
        strobe(10, 5, 1'b0, 16'h0000, 2'd0, "no_cfg_after_reset");

        // Basic hit map
        set_cfg(10, 5, 4, 3, 16'h0100, 2'd2, 1'b1, 1'b0);
        pulse_fs();
        strobe(10, 4, 1'b0, 16'h0000, 2'd2, "above_miss");
        strobe(10, 5, 1'b1, 16'h0100, 2'd2, "hit_10_5");
        strobe(13, 5, 1'b1, 16'h0103, 2'd2, "hit_13_5");
        strobe(14, 5, 1'b0, 16'h0103, 2'd2, "miss_14_5");
        strobe(11, 6, 1'b1, 16'h0105, 2'd2, "hit_11_6");
        strobe(13, 7, 1'b1, 16'h010B, 2'd2, "hit_13_7");
        strobe(10, 8, 1'b0, 16'h010B, 2'd2, "below_10_8");
        strobe(10, 9, 1'b0, 16'h010B, 2'd2, "below_10_9");

        // Shadow timing: mid-frame update must not take effect until frame_start
        pulse_fs();
        strobe(10, 5, 1'b1, 16'h0100, 2'd2, "shadow_hit_10_5");
        set_cfg(20, 5, 4, 3, 16'h0100, 2'd2, 1'b1, 1'b0);
        strobe(10, 6, 1'b1, 16'h0104, 2'd2, "shadow_old_x_10_6");
        strobe(20, 6, 1'b0, 16'h0104, 2'd2, "shadow_new_x_miss");
        pulse_fs();
        strobe(20, 5, 1'b1, 16'h0100, 2'd2, "shadow_new_hit_20_5");
        strobe(10, 5, 1'b0, 16'h0100, 2'd2, "shadow_old_x_miss");
        strobe(21, 5, 1'b1, 16'h0101, 2'd2, "shadow_hit_21_5");
        pulse_fs();
        chk("fs_drops_request", {request, address, layer}, {1'b0, 16'h0101, 2'd2});

        // Address wrap, with update and frame_start in the same cycle
        set_cfg(10, 5, 4, 3, 16'hFFFE, 2'd1, 1'b1, 1'b1);
        strobe(13, 5, 1'b1, 16'h0001, 2'd1, "wrap_13_5");
        strobe(10, 6, 1'b1, 16'h0002, 2'd1, "wrap_10_6");

        // Right-edge clip
        set_cfg(1020, 2, 8, 2, 16'h0200, 2'd0, 1'b1, 1'b1);
        strobe(1023, 2, 1'b1, 16'h0203, 2'd0, "clip_1023");
        strobe(0, 2, 1'b0, 16'h0203, 2'd0, "clip_0_miss");
        strobe(3, 2, 1'b0, 16'h0203, 2'd0, "clip_3_miss");

        // Degenerate sizes
        set_cfg(0, 0, 0, 3, 16'h0300, 2'd3, 1'b1, 1'b1);
        strobe(0, 0, 1'b0, 16'h0203, 2'd3, "w0_miss_0_0");
        strobe(0, 1, 1'b0, 16'h0203, 2'd3, "w0_miss_0_1");
        set_cfg(0, 0, 4, 3, 16'h0300, 2'd3, 1'b0, 1'b1);
        strobe(0, 0, 1'b0, 16'h0203, 2'd3, "dis_miss_0_0");
        strobe(1, 1, 1'b0, 16'h0203, 2'd3, "dis_miss_1_1");

        // Mid-sprite reset
        set_cfg(10, 5, 4, 3, 16'h0100, 2'd2, 1'b1, 1'b1);
        strobe(10, 5, 1'b1, 16'h0100, 2'd2, "pre_reset_hit");
        @(posedge clk); #1;
        pixel_x = 10'd11; pixel_y = 10'd6;
        pixel_strobe = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        pixel_strobe = 1'b0;
        reset = 1'b0;
        chk("mid_sprite_reset", {request, address, layer}, 19'h0);
        pulse_fs();
        strobe(10, 5, 1'b0, 16'h0000, 2'd0, "post_reset_miss_10_5");
        strobe(11, 5, 1'b0, 16'h0000, 2'd0, "post_reset_miss_11_5");

        repeat (5) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending, exp 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
